// File: rtl/rr_mux_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_mux_arbiter_if : M-channel valid/ready source bus plus registered output
// Rev 1.0
// ---------------------------------------------------------------------------
interface rr_mux_arbiter_if #(
  parameter int N = 32,
  parameter int M = 4
);
  localparam int IW = $clog2(M);

  logic [M*N-1:0] inData;
  logic [M-1:0]   inValid;
  logic [M-1:0]   inReady;
  logic           priorityMode;
  logic [N-1:0]   out;
  logic           outValid;
  logic           outReady;
  logic [IW-1:0]  outChannel;

  modport master (
    output inData, inValid, priorityMode, outReady,
    input  inReady, out, outValid, outChannel
  );

  modport slave (
    input  inData, inValid, priorityMode, outReady,
    output inReady, out, outValid, outChannel
  );
endinterface
`default_nettype wire

// File: rtl/rr_mux_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_mux_arbiter : round-robin / fixed-priority M:1 mux into a one-entry stage
// Rev 1.0
// ---------------------------------------------------------------------------
module rr_mux_arbiter #(
  parameter int N = 32,
  parameter int M = 4
) (
  input  wire               clk,
  input  wire               reset,
  rr_mux_arbiter_if.slave   bus
);
  localparam int IW = $clog2(M);
  localparam logic [IW:0]   c_M    = (IW+1)'(M);
  localparam logic [IW-1:0] c_LAST = IW'(M - 1);

  logic [N-1:0]  r_out;
  logic          r_outValid;
  logic [IW-1:0] r_outChannel;
  logic [IW-1:0] r_ptr;

  logic [N-1:0]  w_words [M];
  logic [IW-1:0] w_base;
  logic [M-1:0]  w_rot;
  logic [IW-1:0] w_off;
  logic [IW:0]   w_sum;
  logic [IW-1:0] w_gidx;
  logic          w_gvalid;
  logic          w_space;
  logic          w_xfer;

  for (genvar i = 0; i < M; i++) begin : g_unpack
    assign w_words[i] = bus.inData[i*N +: N];
  end

  // Rotate requests so the search always starts at bit 0; fixed mode uses base 0.
  assign w_base = bus.priorityMode ? '0 : r_ptr;
  assign w_rot  = M'({bus.inValid, bus.inValid} >> w_base);

  always_comb begin
    w_off = '0;
    for (int i = M - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = IW'(i);
    end
  end

  assign w_sum    = {1'b0, w_base} + {1'b0, w_off};
  assign w_gidx   = (w_sum >= c_M) ? IW'(w_sum - c_M) : IW'(w_sum);
  assign w_gvalid = |bus.inValid;
  assign w_space  = ~r_outValid | bus.outReady;
  assign w_xfer   = w_gvalid & w_space;

  assign bus.inReady    = (w_xfer && !reset) ? (M'(1) << w_gidx) : '0;
  assign bus.out        = r_out;
  assign bus.outValid   = r_outValid;
  assign bus.outChannel = r_outChannel;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out        <= '0;
      r_outValid   <= 1'b0;
      r_outChannel <= '0;
      r_ptr        <= '0;
    end else if (w_xfer) begin
      r_out        <= w_words[w_gidx];
      r_outChannel <= w_gidx;
      r_outValid   <= 1'b1;
      if (!bus.priorityMode) begin
        r_ptr <= (w_gidx == c_LAST) ? '0 : w_gidx + 1'b1;
      end
    end else if (bus.outReady) begin
      r_outValid <= 1'b0;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rr_mux_arbiter : directed self-checking bench for rr_mux_arbiter (N=32, M=4)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_rr_mux_arbiter;
  logic clk;
  logic reset;
  int   vecs;
  int   errs;

  rr_mux_arbiter_if #(.N(32), .M(4)) bus ();

  rr_mux_arbiter #(.N(32), .M(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset            = 1'b1;
    bus.inValid      = 4'b1111;
    bus.outReady     = 1'b1;
    bus.priorityMode = 1'b0;
    bus.inData       = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    #1;
    vecs++;
    if (bus.inReady !== 4'b0000) begin
      errs++; $display("FAIL rst_inReady got=%b exp=0000", bus.inReady);
    end
    tick();
    tick();
    vecs++;
    if (bus.outValid !== 1'b0 || bus.out !== 32'h0 || bus.outChannel !== 2'd0) begin
      errs++; $display("FAIL rst_state got v=%b out=%h ch=%0d exp v=0 out=0 ch=0",
                       bus.outValid, bus.out, bus.outChannel);
    end
    vecs++;
    if (bus.inReady !== 4'b0000) begin
      errs++; $display("FAIL rst_inReady_hold got=%b exp=0000", bus.inReady);
    end
    reset       = 1'b0;
    bus.inValid = 4'b0000;
    tick();
    vecs++;
    if (bus.outValid !== 1'b0 || bus.inReady !== 4'b0000) begin
      errs++; $display("FAIL idle got v=%b rdy=%b exp v=0 rdy=0000", bus.outValid, bus.inReady);
    end
  endtask

  task automatic test_round_robin();
    bus.priorityMode = 1'b0;
    bus.outReady     = 1'b1;
    bus.inValid      = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      vecs++;
      if (bus.inReady !== (4'b0001 << (k % 4))) begin
        errs++; $display("FAIL rr_ready k=%0d got=%b exp=%b", k, bus.inReady, 4'b0001 << (k % 4));
      end
      tick();
      vecs++;
      if (bus.outValid !== 1'b1 || bus.outChannel !== 2'(k % 4) || bus.out !== 32'hA0 + 32'(k % 4)) begin
        errs++; $display("FAIL rr_out k=%0d got v=%b ch=%0d out=%h exp v=1 ch=%0d out=%h",
                         k, bus.outValid, bus.outChannel, bus.out, k % 4, 32'hA0 + 32'(k % 4));
      end
    end
  endtask

  task automatic test_fixed_priority();
    bus.priorityMode = 1'b1;
    bus.inValid      = 4'b0110;
    for (int k = 0; k < 3; k++) begin
      #1;
      vecs++;
      if (bus.inReady !== 4'b0010) begin
        errs++; $display("FAIL fix_ready k=%0d got=%b exp=0010", k, bus.inReady);
      end
      tick();
      vecs++;
      if (bus.outChannel !== 2'd1 || bus.out !== 32'hA1) begin
        errs++; $display("FAIL fix_out k=%0d got ch=%0d out=%h exp ch=1 out=a1", k, bus.outChannel, bus.out);
      end
    end
    bus.inValid = 4'b0100;
    #1;
    vecs++;
    if (bus.inReady !== 4'b0100) begin
      errs++; $display("FAIL fix_drop_ready got=%b exp=0100", bus.inReady);
    end
    tick();
    vecs++;
    if (bus.outChannel !== 2'd2 || bus.out !== 32'hA2) begin
      errs++; $display("FAIL fix_drop_out got ch=%0d out=%h exp ch=2 out=a2", bus.outChannel, bus.out);
    end
  endtask

  // Pointer is 1 here: the last round-robin grant was channel 0 and fixed mode held it.
  task automatic test_backpressure();
    bus.priorityMode = 1'b0;
    bus.inValid      = 4'b1111;
    bus.outReady     = 1'b1;
    tick();
    vecs++;
    if (bus.outChannel !== 2'd1 || bus.out !== 32'hA1 || bus.outValid !== 1'b1) begin
      errs++; $display("FAIL bp_first got ch=%0d out=%h v=%b exp ch=1 out=a1 v=1",
                       bus.outChannel, bus.out, bus.outValid);
    end
    bus.outReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      vecs++;
      if (bus.inReady !== 4'b0000) begin
        errs++; $display("FAIL bp_ready k=%0d got=%b exp=0000", k, bus.inReady);
      end
      tick();
      vecs++;
      if (bus.outChannel !== 2'd1 || bus.out !== 32'hA1 || bus.outValid !== 1'b1) begin
        errs++; $display("FAIL bp_hold k=%0d got ch=%0d out=%h v=%b exp ch=1 out=a1 v=1",
                         k, bus.outChannel, bus.out, bus.outValid);
      end
    end
    bus.outReady = 1'b1;
    #1;
    vecs++;
    if (bus.inReady !== 4'b0100) begin
      errs++; $display("FAIL bp_release_ready got=%b exp=0100", bus.inReady);
    end
    tick();
    vecs++;
    if (bus.outChannel !== 2'd2 || bus.out !== 32'hA2 || bus.outValid !== 1'b1) begin
      errs++; $display("FAIL bp_release_out got ch=%0d out=%h v=%b exp ch=2 out=a2 v=1",
                       bus.outChannel, bus.out, bus.outValid);
    end
  endtask

  task automatic test_wrap();
    bus.inValid = 4'b1001;
    #1;
    vecs++;
    if (bus.inReady !== 4'b1000) begin
      errs++; $display("FAIL wrap_ready3 got=%b exp=1000", bus.inReady);
    end
    tick();
    vecs++;
    if (bus.outChannel !== 2'd3 || bus.out !== 32'hA3) begin
      errs++; $display("FAIL wrap_out3 got ch=%0d out=%h exp ch=3 out=a3", bus.outChannel, bus.out);
    end
    vecs++;
    if (bus.inReady !== 4'b0001) begin
      errs++; $display("FAIL wrap_ready0 got=%b exp=0001", bus.inReady);
    end
    tick();
    vecs++;
    if (bus.outChannel !== 2'd0 || bus.out !== 32'hA0) begin
      errs++; $display("FAIL wrap_out0 got ch=%0d out=%h exp ch=0 out=a0", bus.outChannel, bus.out);
    end
    bus.inValid = 4'b0000;
    tick();
    vecs++;
    if (bus.outValid !== 1'b0 || bus.outChannel !== 2'd0 || bus.out !== 32'hA0) begin
      errs++; $display("FAIL drain got v=%b ch=%0d out=%h exp v=0 ch=0 out=a0",
                       bus.outValid, bus.outChannel, bus.out);
    end
  endtask

  // Pointer is 1 entering here; one grant moves it to 2 so the reset is observable.
  task automatic test_reset_mid();
    bus.inValid  = 4'b1111;
    bus.outReady = 1'b1;
    tick();
    vecs++;
    if (bus.outChannel !== 2'd1 || bus.outValid !== 1'b1) begin
      errs++; $display("FAIL mid_pre got ch=%0d v=%b exp ch=1 v=1", bus.outChannel, bus.outValid);
    end
    bus.outReady = 1'b0;
    tick();
    reset        = 1'b1;
    bus.outReady = 1'b1;
    #1;
    vecs++;
    if (bus.inReady !== 4'b0000) begin
      errs++; $display("FAIL mid_rst_ready got=%b exp=0000", bus.inReady);
    end
    tick();
    vecs++;
    if (bus.outValid !== 1'b0 || bus.out !== 32'h0 || bus.outChannel !== 2'd0) begin
      errs++; $display("FAIL mid_rst_state got v=%b out=%h ch=%0d exp v=0 out=0 ch=0",
                       bus.outValid, bus.out, bus.outChannel);
    end
    reset = 1'b0;
    #1;
    vecs++;
    if (bus.inReady !== 4'b0001) begin
      errs++; $display("FAIL mid_after_ready got=%b exp=0001", bus.inReady);
    end
    tick();
    vecs++;
    if (bus.outChannel !== 2'd0 || bus.out !== 32'hA0 || bus.outValid !== 1'b1) begin
      errs++; $display("FAIL mid_after_out got ch=%0d out=%h v=%b exp ch=0 out=a0 v=1",
                       bus.outChannel, bus.out, bus.outValid);
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Parametrised successor of the 2:1 word mux: selects one of M valid/ready source channels, each N bits wide, and registers the chosen word into a one-entry output stage.
- Arbitration is round-robin or fixed-priority, chosen at run time.
- Sits between multiple requesters and a single shared consumer. Examples: instruction fetch vs. data memory port, or several writeback sources into the register file.
- Sustains one transfer per cycle with 1-cycle latency.

Parameters:
- N, 32, data width of each channel and of the output word.
- M, 4, number of source channels (2..16).
- IW, $clog2(M), width of the channel-index output (derived; not overridden).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- inData  input  M*N  channel i occupies bits [i*N+N-1 : i*N].
- inValid  input  M  channel i presents a word.
- inReady  output  M  channel i's word is accepted this cycle (one-hot or zero).
- priorityMode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins).
- out  output  N  registered selected word.
- outValid  output  1  out holds an unconsumed word.
- outReady  input  1  consumer accepts out this cycle.
- outChannel  output  IW  index of the channel that produced out.

Behaviour:
- Reset (reset=1 at a rising edge): out=0, outValid=0, outChannel=0, round-robin pointer ptr=0. inReady is combinational and reads 0 while outValid=0 only if inValid=0.
- Reset mid-transfer: a pending output word is discarded, with no handshake completion. Inputs presented in the reset cycle are not accepted; inReady is forced to 0 while reset=1.
- Stage capacity: space = ~outValid | outReady (pass-through when the consumer drains in the same cycle).
- Grant, combinational:
  - priorityMode=1: the lowest i with inValid[i]=1.
  - priorityMode=0: the first i with inValid[i]=1, searching ptr, ptr+1, ..., M-1, 0, ..., ptr-1 (mod M).
  - No valid input: no grant.
- inReady[i] = grant[i] & space & ~reset. At most one bit is set.
- Transfer: occurs when a grant exists and space=1. At the next edge:
  - out <= the granted channel's word;
  - outChannel <= g;
  - outValid <= 1;
  - in round-robin mode, ptr <= (g+1) mod M, wrapping from M-1 to 0.
- In fixed mode ptr is held. Switching modes takes effect in the same cycle; ptr is preserved.
- Drain without refill: if outValid & outReady and there is no transfer, outValid <= 0. out and outChannel hold their last values.
- Simultaneous drain and refill: outValid stays 1 and the new word replaces the old one in one edge, with no bubble. Throughput is 1 word/cycle.
- Stall: if outValid & ~outReady, then out, outChannel and outValid hold; inReady=0; ptr holds.
- Stability: sources must keep inData and inValid stable until accepted. The block does not depend on this for correctness; it samples only on transfer.
- Latency: a word accepted at edge k is visible on out after edge k. No combinational path exists from inData to out.
- outValid, out and outChannel are pure register outputs.

Test Plan:
- Reset/idle (N=32, M=4): assert reset 2 cycles with all inValid=1 -> inReady=0000, outValid=0, out=0. Release with all inValid=0 -> outValid remains 0.
- Round-robin fairness: priorityMode=0, all four channels valid with inData[i]=0xA0+i, outReady=1 -> outChannel sequence 0,1,2,3,0,... with one word per cycle, out=0xA0,0xA1,0xA2,0xA3,0xA0.
- Fixed priority: priorityMode=1, inValid=0110 (channels 1 and 2), outReady=1 -> channel 1 granted every cycle and channel 2 never. Drop inValid[1] -> channel 2 granted next cycle.
- Backpressure: one word accepted, then outReady=0 for 3 cycles with inValid=1111 -> inReady=0000 and out/outChannel stable for all 3 cycles. outReady=1 -> drain and next grant complete in the same cycle.
- Pointer wrap/skip: priorityMode=0, ptr=3 after a grant to channel 2, inValid=1001 -> channel 3 granted, then channel 0 (ptr wraps to 0, then 1).
- Reset mid-operation: outValid=1, outReady=0, reset pulsed 1 cycle -> outValid=0, out=0, ptr=0. The next grant with inValid=1111 goes to channel 0.
